// File: rtl/fp_div_iter.sv
`timescale 1ns/1ps
// fp_div_iter: parametrised iterative IEEE-754 divider (restoring, 1 quotient bit/cycle, RNE, full flags).
// Define FP_DIV_EARLY_OUT_EN to route special operands straight from IDLE to OUT.
module fp_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = (1 << (EXP_W - 1)) - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 inexact,
  output logic                 div_by_zero,
  output logic                 invalid
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // ITER  | N+3 restoring divide steps, one quotient bit each
  // NORM  | bring quotient into [1,2), adjust exponent
  // ROUND | RNE, range check, special-operand override
  // OUT   | result and flags held until out_ready

  localparam int FW  = 1 + EXP_W + MAN_W;
  localparam int N   = MAN_W;
  localparam int EW2 = EXP_W + 2;
  localparam int CW  = $clog2(N + 3);
  localparam logic signed [EW2-1:0] EXP_TOP  = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] EXP_BIAS = EW2'(BIAS);
  localparam logic [CW-1:0]         CNT_LOAD = CW'(N + 2);
  localparam logic [FW-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ITER, S_NORM, S_ROUND, S_OUT} state_t;

  state_t state_q, state_d;

  logic [EXP_W-1:0]      ea, eb;
  logic [N-1:0]          ma, mb;
  logic                  a_max, a_zero, b_max, b_zero;
  logic                  a_nan, b_nan, a_inf, b_inf;
  logic                  special, sgn;
  logic [FW-1:0]         spec_res;
  logic [4:0]            spec_flg;

  logic                  sign_q;
  logic signed [EW2-1:0] exp_q;
  logic [N+1:0]          rem_q;
  logic [N:0]            div_q;
  logic [N+2:0]          quo_q;
  logic [CW-1:0]         cnt_q;
  logic                  spec_q;
  logic [FW-1:0]         spec_res_q;
  logic [4:0]            spec_flg_q;
  logic [4:0]            flg_q;

  logic                  q_bit;
  logic [N+1:0]          rem_sub, rem_nx;
  logic                  g, r, st, up;
  logic [N:0]            man_rnd;
  logic signed [EW2-1:0] exp_r;
  logic                  rnd_ovf, rnd_unf;

  assign ea     = a[FW-2:N];
  assign eb     = b[FW-2:N];
  assign ma     = a[N-1:0];
  assign mb     = b[N-1:0];
  assign a_max  = &ea;
  assign b_max  = &eb;
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;
  assign a_nan  = a_max & (|ma);
  assign b_nan  = b_max & (|mb);
  assign a_inf  = a_max & ~(|ma);
  assign b_inf  = b_max & ~(|mb);
  assign special = a_max | a_zero | b_max | b_zero;
  assign sgn    = a[FW-1] ^ b[FW-1];

  // Subnormals decode as zero because only the exponent field is inspected.
  always_comb begin
    spec_res = '0;
    spec_flg = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = QNAN;
      spec_flg = 5'b00001;
    end else if (a_inf) begin
      spec_res = {sgn, {EXP_W{1'b1}}, {N{1'b0}}};
    end else if (b_zero) begin
      spec_res = {sgn, {EXP_W{1'b1}}, {N{1'b0}}};
      spec_flg = 5'b00010;
    end else begin
      spec_res = {sgn, {(FW-1){1'b0}}};
    end
  end

  assign q_bit   = (rem_q >= {1'b0, div_q});
  assign rem_sub = rem_q - {1'b0, div_q};
  assign rem_nx  = q_bit ? rem_sub : rem_q;

  // After NORM the quotient's lsb pair is guard/round; leftover remainder is sticky.
  assign g       = quo_q[1];
  assign r       = quo_q[0];
  assign st      = |rem_q;
  assign up      = g & (r | st | quo_q[2]);
  assign man_rnd = {1'b0, quo_q[N+1:2]} + {{N{1'b0}}, up};
  assign exp_r   = exp_q + $signed({{(EW2-1){1'b0}}, man_rnd[N]});
  assign rnd_ovf = (exp_r >= EXP_TOP);
  assign rnd_unf = exp_r[EW2-1] || (exp_r == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
`ifdef FP_DIV_EARLY_OUT_EN
        state_d = special ? S_OUT : S_ITER;
`else
        state_d = S_ITER;
`endif
      end
      S_ITER:  if (cnt_q == '0) state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q     <= 1'b0;
      exp_q      <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_flg_q <= '0;
      result     <= '0;
      flg_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          sign_q     <= sgn;
          exp_q      <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + EXP_BIAS;
          rem_q      <= {2'b01, ma};
          div_q      <= {1'b1, mb};
          quo_q      <= '0;
          cnt_q      <= CNT_LOAD;
          spec_q     <= special;
          spec_res_q <= spec_res;
          spec_flg_q <= spec_flg;
`ifdef FP_DIV_EARLY_OUT_EN
          if (special) begin
            result <= spec_res;
            flg_q  <= spec_flg;
          end
`endif
        end
        S_ITER: begin
          quo_q <= {quo_q[N+1:0], q_bit};
          rem_q <= rem_nx << 1;
          cnt_q <= cnt_q - 1'b1;
        end
        S_NORM: if (!quo_q[N+2]) begin
          quo_q <= quo_q << 1;
          exp_q <= exp_q - EW2'(1);
        end
        S_ROUND: begin
          if (spec_q) begin
            result <= spec_res_q;
            flg_q  <= spec_flg_q;
          end else if (rnd_ovf) begin
            result <= {sign_q, {EXP_W{1'b1}}, {N{1'b0}}};
            flg_q  <= 5'b10100;
          end else if (rnd_unf) begin
            result <= {sign_q, {(FW-1){1'b0}}};
            flg_q  <= 5'b01100;
          end else begin
            result <= {sign_q, exp_r[EXP_W-1:0], man_rnd[N-1:0]};
            flg_q  <= {2'b00, g | r | st, 2'b00};
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign {overflow, underflow, inexact, div_by_zero, invalid} = flg_q;

endmodule

// File: tb/tb_fp_div_iter.sv
`timescale 1ns/1ps
// Scoreboard bench for fp_div_iter: single-precision random + directed vectors, half-precision spot checks.
module tb_fp_div_iter;
  localparam int MW = 23;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid;
  logic [31:0] result;
  logic        overflow, underflow, inexact, div_by_zero, invalid;
  logic [4:0]  flg;

  logic        h_in_valid = 1'b0, h_out_ready = 1'b1;
  logic [15:0] h_a = '0, h_b = '0;
  logic        h_in_ready, h_out_valid;
  logic [15:0] h_result;
  logic        h_ovf, h_unf, h_inx, h_dbz, h_inv;

  always #5 clk = ~clk;

  fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .inexact(inexact),
    .div_by_zero(div_by_zero), .invalid(invalid));

  fp_div_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result),
    .overflow(h_ovf), .underflow(h_unf), .inexact(h_inx),
    .div_by_zero(h_dbz), .invalid(h_inv));

  assign flg = {overflow, underflow, inexact, div_by_zero, invalid};

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flg;
    int          t_acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer quotient of the significands, RNE decided from the remainder.
  function automatic logic [36:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic   s, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    longint mav, mbv, num, sig, rem, e;
    s      = x[31] ^ y[31];
    x_zero = (x[30:23] == 8'h00);
    y_zero = (y[30:23] == 8'h00);
    x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) return {32'h7FC00000, 5'b00001};
    if (x_inf)  return {s, 8'hFF, 23'd0, 5'b00000};
    if (y_zero) return {s, 8'hFF, 23'd0, 5'b00010};
    if (x_zero || y_inf) return {s, 31'd0, 5'b00000};
    mav = longint'({1'b1, x[22:0]});
    mbv = longint'({1'b1, y[22:0]});
    e   = longint'(x[30:23]) - longint'(y[30:23]) + 127;
    if (mav < mbv) begin
      num = mav << (MW + 1);
      e   = e - 1;
    end else begin
      num = mav << MW;
    end
    sig = num / mbv;
    rem = num % mbv;
    if ((2 * rem > mbv) || ((2 * rem == mbv) && sig[0])) sig = sig + 1;
    if (sig == (longint'(1) << (MW + 1))) begin
      sig = longint'(1) << MW;
      e   = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0, 5'b10100};
    if (e <= 0)   return {s, 31'd0, 5'b01100};
    return {s, e[7:0], sig[22:0], 2'b00, (rem != 0), 2'b00};
  endfunction

  function automatic int lat_of(input logic [31:0] x, input logic [31:0] y);
`ifdef FP_DIV_EARLY_OUT_EN
    if (x[30:23] == 8'h00 || x[30:23] == 8'hFF || y[30:23] == 8'h00 || y[30:23] == 8'hFF) return 1;
`endif
    return MW + 6;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] m;
    int          k;
    k = $urandom_range(0, 15);
    m = 23'($urandom);
    if (k == 0) begin
      e = 8'h00;
      if ($urandom_range(0, 1) == 0) m = '0;
    end else if (k == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) m = '0;
    end else if (k < 4) begin
      e = 8'($urandom_range(1, 254));
    end else begin
      e = 8'($urandom_range(107, 147));
    end
    if (k > 1 && $urandom_range(0, 7) == 0) m = '0;
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input logic [36:0] e,
                       input bit track, output int t_acc);
    int   guard;
    exp_t ent;
    @(negedge clk);
    a = xa;
    b = xb;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    t_acc = cyc;
    if (!in_ready) begin
      $display("FAIL accept_timeout a=%h b=%h in_ready=%b want 1", xa, xb, in_ready);
      n_err++;
    end else if (track) begin
      ent.a = xa; ent.b = xb; ent.res = e[36:5]; ent.flg = e[4:0];
      ent.t_acc = cyc; ent.lat = lat_of(xa, xb);
      sb.push_back(ent);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_half(input logic [15:0] xa, input logic [15:0] xb, input logic [15:0] e_res);
    int guard, t0;
    @(negedge clk);
    h_a = xa;
    h_b = xb;
    h_in_valid = 1'b1;
    guard = 0;
    while (!h_in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    t0 = cyc;
    @(negedge clk);
    h_in_valid = 1'b0;
    guard = 0;
    while (!h_out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (!h_out_valid || (cyc - t0) != 16 || h_result !== e_res ||
        {h_ovf, h_unf, h_inx, h_dbz, h_inv} !== 5'b00000) begin
      $display("FAIL half a=%h b=%h got=%h flags=%b lat=%0d exp=%h flags=00000 lat=16",
               xa, xb, h_result, {h_ovf, h_unf, h_inx, h_dbz, h_inv}, cyc - t0, e_res);
      n_err++;
    end
  endtask

  // Monitor: pops and compares on each output handshake; stalls every fourth result for 5 cycles.
  initial begin
    exp_t        cur;
    logic [31:0] held;
    logic [4:0]  held_f;
    logic        ov_prev;
    int          stall, n_res;
    ov_prev = 1'b0; stall = 0; n_res = 0; held = '0; held_f = '0;
    forever begin
      @(negedge clk);
      if (out_valid && !ov_prev) begin
        held = result;
        held_f = flg;
        stall = (n_res % 4 == 0) ? 5 : 0;
        n_res++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_output result=%h flags=%b want no output", result, flg);
          n_err++;
        end else begin
          cur = sb[0];
          if ((cyc - cur.t_acc) != cur.lat) begin
            $display("FAIL latency a=%h b=%h got=%0d exp=%0d", cur.a, cur.b, cyc - cur.t_acc, cur.lat);
            n_err++;
          end
        end
      end
      if (out_valid && (result !== held || flg !== held_f || in_ready !== 1'b0)) begin
        $display("FAIL hold result=%h flags=%b in_ready=%b exp=%h flags=%b in_ready=0",
                 result, flg, in_ready, held, held_f);
        n_err++;
      end
      ov_prev = out_valid;
      if (out_valid && stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        cur = sb.pop_front();
        n_vec++;
        if (result !== cur.res || flg !== cur.flg) begin
          $display("FAIL result a=%h b=%h got=%h flags=%b exp=%h flags=%b",
                   cur.a, cur.b, result, flg, cur.res, cur.flg);
          n_err++;
        end
      end
    end
  end

  initial begin
    logic [31:0] dir_a [6];
    logic [31:0] dir_b [6];
    logic [36:0] dir_e [6];
    logic [31:0] x, y;
    int          t, guard;

    dir_a = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h7F000000, 32'h00800000};
    dir_b = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h3E800000, 32'h47000000};
    dir_e = '{{32'h40400000, 5'b00000}, {32'h3EAAAAAB, 5'b00100}, {32'h7F800000, 5'b00010},
              {32'h7FC00000, 5'b00001}, {32'h7F800000, 5'b10100}, {32'h00000000, 5'b01100}};

    repeat (3) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || flg !== 5'b0) begin
      $display("FAIL reset_state in_ready=%b out_valid=%b result=%h flags=%b exp 1/0/0/0",
               in_ready, out_valid, result, flg);
      n_err++;
    end
    rst = 1'b0;

    for (int i = 0; i < 6; i++) issue(dir_a[i], dir_b[i], dir_e[i], 1'b1, t);
    for (int i = 0; i < 150; i++) begin
      x = rand_fp();
      y = rand_fp();
      issue(x, y, ref_div(x, y), 1'b1, t);
    end

    guard = 0;
    while ((sb.size() != 0 || out_valid) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      $display("FAIL drain pending=%0d exp 0", sb.size());
      n_err++;
    end

    // Abort mid-iteration: no result may ever appear.
    issue(32'h40C00000, 32'h40000000, 37'd0, 1'b0, t);
    while (cyc < t + 10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0 || flg !== 5'b0) begin
      $display("FAIL mid_reset out_valid=%b in_ready=%b result=%h flags=%b exp 0/1/0/0",
               out_valid, in_ready, result, flg);
      n_err++;
    end
    rst = 1'b0;
    repeat (40) @(negedge clk);

    issue(32'h40C00000, 32'h40000000, {32'h40400000, 5'b00000}, 1'b1, t);
    guard = 0;
    while ((sb.size() != 0 || out_valid) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      $display("FAIL post_reset_drain pending=%0d exp 0", sb.size());
      n_err++;
    end

    run_half(16'h3C00, 16'h4000, 16'h3800);
    run_half(16'hBC00, 16'h4000, 16'hB800);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
